sim_ft_fifo_dev: RTL

Parametrised behavioural model of an FTDI synchronous-FIFO device: FT2232H 8-bit, or FT600/FT601 16/32-bit data width. It is the simulation partner for the FPGA-side FIFO controller in the loop-back testbenches. It sources an incrementing word stream into the FPGA and checks the stream returned by the FPGA. It adds features a single-byte model lacks: finite RX/TX buffers with real RXF#/TXE# back-pressure, bursty RX availability, a throttled host drain, protocol checking and error counters.

---
 rtl/sim_ft_pkg.sv | 24 ++
 rtl/sim_ft_buf.sv | 51 +++++
 rtl/sim_ft_fifo_dev.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sim_ft_pkg.sv
// Shared types and helpers for the FTDI synchronous-FIFO device model.
// Used by the buffer sub-module and the device top.
package sim_ft_pkg;

    typedef enum logic {
        ST_RUN,
        ST_GAP
    } burst_state_e;

    localparam string DBG_RED   = "\033[1;31m";
    localparam string DBG_GREEN = "\033[1;32m";
    localparam string DBG_RESET = "\033[0m";

    function automatic bit width_ok(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic int log2c(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sim_ft_buf.sv
// Synchronous FIFO buffer; dout is the current head word.
// A push on a full buffer is accepted only together with a pop.
module sim_ft_buf
    import sim_ft_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [log2c(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = log2c(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sim_ft_fifo_dev.sv
// Behavioural FTDI sync-FIFO device: sources an incrementing RX stream,
// sinks and checks the TX stream, with back-pressure and protocol checks.
module sim_ft_fifo_dev
    import sim_ft_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int RX_DEPTH        = 16,
    parameter int TX_DEPTH        = 16,
    parameter int WORDS_TO_SEND   = 256,
    parameter int RX_BURST        = 0,
    parameter int RX_GAP          = 4,
    parameter int TX_DRAIN_PERIOD = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  fifo_rxf_n_o,
    output logic                  fifo_txe_n_o,
    input  logic                  fifo_oe_n_i,
    input  logic                  fifo_rd_n_i,
    input  logic                  fifo_wr_n_i,
    inout  wire  [DATA_WIDTH-1:0] fifo_data_io,
    output logic                  rx_done_o,
    output logic                  tx_done_o,
    output logic [31:0]           tx_rcv_cnt_o,
    output logic [15:0]           tx_err_cnt_o,
    output logic                  proto_err_o
);

    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
        $fatal(1, "sim_ft_fifo_dev: DATA_WIDTH must be 8, 16 or 32");
    end

    localparam int          RXC        = log2c(RX_DEPTH) + 1;
    localparam int          TXC        = log2c(TX_DEPTH) + 1;
    localparam logic [31:0] WORDS      = 32'(WORDS_TO_SEND);
    localparam logic [31:0] BURST_LAST = 32'(RX_BURST - 1);
    localparam logic [31:0] GAP_LAST   = 32'(RX_GAP - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(TX_DRAIN_PERIOD - 1);

    logic                  gen_en;
    logic [31:0]           gen_k;
    logic                  oe_q;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] rx_dout;
    logic [RXC-1:0]        rx_count, rx_count_next;
    logic [31:0]           rx_pop_cnt;
    burst_state_e          state;
    logic [31:0]           burst_cnt, gap_cnt;
    logic                  enter_gap, leave_gap;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0] tx_dout, tx_exp;
    logic [TXC-1:0]        tx_count, tx_count_next;
    logic [31:0]           drain_cnt;
    logic                  rd_early, wr_on_oe;

    // Generator waits one edge after reset so RXF# first falls on edge two.
    assign rx_push = gen_en && !rx_full && (gen_k < WORDS);
    assign rd_early = !fifo_rd_n_i && !fifo_oe_n_i && oe_q;
    assign rx_pop   = !fifo_rxf_n_o && !fifo_oe_n_i && !fifo_rd_n_i && !oe_q;
    assign rx_count_next = rx_count + RXC'(rx_push) - RXC'(rx_pop);

    assign enter_gap = (RX_BURST != 0) && (RX_GAP != 0) && (state == ST_RUN)
                       && rx_pop && (burst_cnt == BURST_LAST);
    assign leave_gap = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    assign fifo_data_io = fifo_oe_n_i ? {DATA_WIDTH{1'bz}}
                                      : (rx_empty ? '0 : rx_dout);

    assign tx_push = !fifo_txe_n_o && !tx_full && fifo_oe_n_i && !fifo_wr_n_i;
    assign tx_pop  = (drain_cnt == DRAIN_LAST) && !tx_empty;
    assign tx_count_next = tx_count + TXC'(tx_push) - TXC'(tx_pop);
    assign wr_on_oe = !fifo_wr_n_i && !fifo_oe_n_i;

    sim_ft_buf #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_buf (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (gen_k[DATA_WIDTH-1:0]),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sim_ft_buf #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_buf (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (fifo_data_io),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gen_en       <= 1'b0;
            gen_k        <= '0;
            oe_q         <= 1'b1;
            rx_pop_cnt   <= '0;
            rx_done_o    <= 1'b0;
            proto_err_o  <= 1'b0;
            state        <= ST_RUN;
            burst_cnt    <= '0;
            gap_cnt      <= '0;
            fifo_rxf_n_o <= 1'b1;
        end else begin
            gen_en <= 1'b1;
            oe_q   <= fifo_oe_n_i;
            if (rx_push) gen_k <= gen_k + 32'd1;
            if (rx_pop) begin
                rx_pop_cnt <= rx_pop_cnt + 32'd1;
                if (rx_pop_cnt + 32'd1 == WORDS) rx_done_o <= 1'b1;
            end
            if (rd_early || wr_on_oe) proto_err_o <= 1'b1;
            unique case (state)
                ST_RUN: begin
                    if (enter_gap) begin
                        state     <= ST_GAP;
                        burst_cnt <= '0;
                        gap_cnt   <= '0;
                    end else if (rx_pop) begin
                        burst_cnt <= burst_cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (leave_gap) state <= ST_RUN;
                    else gap_cnt <= gap_cnt + 32'd1;
                end
            endcase
            fifo_rxf_n_o <= (rx_count_next == '0) || enter_gap
                            || ((state == ST_GAP) && !leave_gap);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_txe_n_o <= 1'b0;
            drain_cnt    <= '0;
            tx_exp       <= '0;
            tx_rcv_cnt_o <= '0;
            tx_err_cnt_o <= '0;
            tx_done_o    <= 1'b0;
        end else begin
            fifo_txe_n_o <= (tx_count_next == TXC'(TX_DEPTH));
            drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 32'd1;
            if (tx_pop) begin
                tx_exp       <= tx_exp + 1'b1;
                tx_rcv_cnt_o <= tx_rcv_cnt_o + 32'd1;
                if (tx_rcv_cnt_o + 32'd1 == WORDS) tx_done_o <= 1'b1;
                if (tx_dout != tx_exp && tx_err_cnt_o != 16'hFFFF)
                    tx_err_cnt_o <= tx_err_cnt_o + 16'd1;
            end
        end
    end

endmodule
